// File: rtl/hazard_fwd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl_pkg
// Shared definitions for the pipeline hazard / forwarding controller:
//   - forwarding mux select encodings for the EX-stage operand muxes
//   - stage_rec_t, the per-stage shadow record (EX, MEM, WB)
//   - rec_produces(), the "this record will write register r" test
// -----------------------------------------------------------------------------
package hazard_fwd_ctrl_pkg;

    // Register-address width of the shadow records. The top-level
    // REG_ADDR_W parameter defaults to this value and must stay equal to it.
    localparam int REC_ADDR_W = 5;

    // EX operand mux selects; 2'b11 is never produced.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REC_ADDR_W-1:0] rs;
        logic [REC_ADDR_W-1:0] rt;
        logic                  uses_rs;
        logic                  uses_rt;
        logic [REC_ADDR_W-1:0] dest;
        logic                  regwrite;
        logic                  memread;
    } stage_rec_t;

    // A record produces r when it is a real instruction that writes r.
    // Register 0 is hard-wired to zero, so it is never produced.
    function automatic logic rec_produces(input stage_rec_t rec,
                                          input logic [REC_ADDR_W-1:0] r);
        return rec.valid && rec.regwrite && (rec.dest == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// -----------------------------------------------------------------------------
// hazard_stage_rec
// One shadow-pipeline record register with asynchronous active-low clear.
// Ports:
//   clk, rst_n  - core clock, async active-low reset (clears the record)
//   i_load      - capture i_rec on the next rising edge
//   i_bubble    - capture an empty record instead (wins over i_load)
//   i_rec       - incoming record from the previous stage
//   o_rec       - registered record
// -----------------------------------------------------------------------------
module hazard_stage_rec
    import hazard_fwd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_bubble,
    input  stage_rec_t i_rec,
    output stage_rec_t o_rec
);

    stage_rec_t r_rec;

    // A bubble clears every field, so valid/regwrite/memread are all 0 and
    // the uses_* bits cannot trigger forwarding for an empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec <= '0;
        end else if (i_bubble) begin
            r_rec <= '0;
        end else if (i_load) begin
            r_rec <= i_rec;
        end
    end

    assign o_rec = r_rec;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard detection and forwarding control for the 5-stage MIPS pipeline.
// Keeps its own EX/MEM/WB shadow records fed from the ID stage and drives:
//   - EX operand mux selects (register file / WB result / MEM ALU result)
//   - ID branch-comparator bypass from the MEM ALU result
//   - stall (hold PC and IF/ID) and idex_flush (bubble into ID/EX)
// Ports:
//   clk, rst_n                      - core clock, async active-low reset
//   i_id_valid                      - ID holds a real instruction
//   i_id_rs, i_id_rt                - ID source registers
//   i_id_uses_rs, i_id_uses_rt      - ID instruction reads rs / rt
//   i_id_dest                       - resolved destination register
//   i_id_regwrite, i_id_memread     - writes register file / is a load
//   i_id_branch                     - branch compared in ID
//   o_stall, o_idex_flush           - hold IF/ID, bubble ID/EX
//   o_fwd_a_sel, o_fwd_b_sel        - EX operand mux selects
//   o_br_fwd_a, o_br_fwd_b          - ID comparator takes MEM ALU result
// All outputs are combinational from the ID inputs and the shadow records.
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REC_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rs,
    input  logic                  i_id_uses_rt,
    input  logic [REG_ADDR_W-1:0] i_id_dest,
    input  logic                  i_id_regwrite,
    input  logic                  i_id_memread,
    input  logic                  i_id_branch,
    output logic                  o_stall,
    output logic                  o_idex_flush,
    output logic [1:0]            o_fwd_a_sel,
    output logic [1:0]            o_fwd_b_sel,
    output logic                  o_br_fwd_a,
    output logic                  o_br_fwd_b
);

    stage_rec_t w_id_rec;
    stage_rec_t w_ex;
    stage_rec_t w_mem;
    stage_rec_t w_wb;

    logic w_use_rs;
    logic w_use_rt;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_load_use;
    logic w_br_stall;
    logic w_stall;

    // EX-stage operand select: MEM ALU result beats WB on a double match
    // because it is the younger write. A load in MEM cannot forward (its data
    // is not ready); the stall logic keeps a consumer out of EX in that case.
    function automatic logic [1:0] ex_fwd_sel(input logic                  uses,
                                              input logic [REC_ADDR_W-1:0] r,
                                              input stage_rec_t            mem,
                                              input stage_rec_t            wb);
        logic [1:0] sel;
        sel = FWD_REG;
        if (uses) begin
            if (rec_produces(mem, r) && !mem.memread) begin
                sel = FWD_MEM;
            end else if (rec_produces(wb, r)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    // ID fields packed into a record for the EX stage.
    always_comb begin
        w_id_rec          = '0;
        w_id_rec.valid    = i_id_valid;
        w_id_rec.rs       = REC_ADDR_W'(i_id_rs);
        w_id_rec.rt       = REC_ADDR_W'(i_id_rt);
        w_id_rec.uses_rs  = i_id_uses_rs;
        w_id_rec.uses_rt  = i_id_uses_rt;
        w_id_rec.dest     = REC_ADDR_W'(i_id_dest);
        w_id_rec.regwrite = i_id_regwrite;
        w_id_rec.memread  = i_id_memread;
    end

    // Shadow pipeline: EX takes ID or a bubble, MEM and WB simply shift.
    hazard_stage_rec u_ex_rec (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (1'b1),
        .i_bubble (w_stall | ~i_id_valid),
        .i_rec    (w_id_rec),
        .o_rec    (w_ex)
    );

    hazard_stage_rec u_mem_rec (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (1'b1),
        .i_bubble (1'b0),
        .i_rec    (w_ex),
        .o_rec    (w_mem)
    );

    hazard_stage_rec u_wb_rec (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (1'b1),
        .i_bubble (1'b0),
        .i_rec    (w_mem),
        .o_rec    (w_wb)
    );

    // Source reads of the ID instruction; a bubble in ID reads nothing,
    // which also gates every stall and bypass below.
    assign w_use_rs = i_id_valid & i_id_uses_rs;
    assign w_use_rt = i_id_valid & i_id_uses_rt;

    assign w_ex_hit  = (w_use_rs & rec_produces(w_ex,  w_id_rec.rs)) |
                       (w_use_rt & rec_produces(w_ex,  w_id_rec.rt));
    assign w_mem_hit = (w_use_rs & rec_produces(w_mem, w_id_rec.rs)) |
                       (w_use_rt & rec_produces(w_mem, w_id_rec.rt));

    // Load-use: a load in EX cannot forward to the next instruction in time.
    assign w_load_use = w_ex.memread & w_ex_hit;

    // Branches compare in ID, so any producer still in EX must wait one
    // cycle, and a load in MEM must wait until its data reaches WB.
    assign w_br_stall = i_id_branch & (w_ex_hit | (w_mem.memread & w_mem_hit));

    assign w_stall = w_load_use | w_br_stall;

    assign o_stall      = w_stall;
    assign o_idex_flush = w_stall;

    assign o_fwd_a_sel = ex_fwd_sel(w_ex.uses_rs, w_ex.rs, w_mem, w_wb);
    assign o_fwd_b_sel = ex_fwd_sel(w_ex.uses_rt, w_ex.rt, w_mem, w_wb);

    // WB needs no branch bypass: the register file writes in the first half
    // of the cycle and ID reads in the second half.
    assign o_br_fwd_a = i_id_branch & w_use_rs &
                        rec_produces(w_mem, w_id_rec.rs) & ~w_mem.memread;
    assign o_br_fwd_b = i_id_branch & w_use_rt &
                        rec_produces(w_mem, w_id_rec.rt) & ~w_mem.memread;

    // Record fields that no downstream comparison needs.
    logic w_unused;
    assign w_unused = ^{w_mem.rs, w_mem.rt, w_mem.uses_rs, w_mem.uses_rt,
                        w_wb.rs, w_wb.rt, w_wb.uses_rs, w_wb.uses_rt,
                        w_wb.memread};

`ifndef SYNTHESIS
    // A load in MEM with a dependent instruction in EX means a load-use
    // stall was missed.
    a_no_load_consumer: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_mem.memread &&
          ((w_ex.uses_rs && rec_produces(w_mem, w_ex.rs)) ||
           (w_ex.uses_rt && rec_produces(w_mem, w_ex.rt)))));

    a_fwd_sel_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (o_fwd_a_sel != 2'b11) && (o_fwd_b_sel != 2'b11));
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Drives instruction streams into the ID-side inputs of hazard_fwd_ctrl and
// compares every cycle's outputs against a reference model that keeps the
// list of instructions that reached EX (newest first), plus directed checks
// for the listed pipeline scenarios.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dest;
        logic       rw;
        logic       mr;
        logic       br;
    } ins_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic       i_id_valid;
    logic [4:0] i_id_rs;
    logic [4:0] i_id_rt;
    logic       i_id_uses_rs;
    logic       i_id_uses_rt;
    logic [4:0] i_id_dest;
    logic       i_id_regwrite;
    logic       i_id_memread;
    logic       i_id_branch;
    logic       o_stall;
    logic       o_idex_flush;
    logic [1:0] o_fwd_a_sel;
    logic [1:0] o_fwd_b_sel;
    logic       o_br_fwd_a;
    logic       o_br_fwd_b;

    hazard_fwd_ctrl #(.REG_ADDR_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_id_valid    (i_id_valid),
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .i_id_uses_rs  (i_id_uses_rs),
        .i_id_uses_rt  (i_id_uses_rt),
        .i_id_dest     (i_id_dest),
        .i_id_regwrite (i_id_regwrite),
        .i_id_memread  (i_id_memread),
        .i_id_branch   (i_id_branch),
        .o_stall       (o_stall),
        .o_idex_flush  (o_idex_flush),
        .o_fwd_a_sel   (o_fwd_a_sel),
        .o_fwd_b_sel   (o_fwd_b_sel),
        .o_br_fwd_a    (o_br_fwd_a),
        .o_br_fwd_b    (o_br_fwd_b)
    );

    // ---------------- scoreboard state ----------------
    // Output vector: {stall, flush, fwd_a[1:0], fwd_b[1:0], br_a, br_b}
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    // Reference model: hist[0] is the instruction now in EX, hist[1] in MEM,
    // hist[2] in WB. Empty slots are all-zero.
    ins_t hist[$];
    ins_t last_id;
    logic last_stall;

    function automatic logic [7:0] dut_out();
        return {o_stall, o_idex_flush, o_fwd_a_sel, o_fwd_b_sel,
                o_br_fwd_a, o_br_fwd_b};
    endfunction

    // Instruction i will write register r (register 0 never counts).
    function automatic logic writes(input ins_t i, input logic [4:0] r);
        return i.valid && i.rw && (i.dest == r) && (r != 5'd0);
    endfunction

    // Where an EX-stage operand reading r must come from.
    function automatic logic [1:0] operand_src(input ins_t mem, input ins_t wb,
                                               input logic used, input logic [4:0] r);
        if (!used) return 2'b00;
        if (writes(mem, r) && !mem.mr) return 2'b10;
        if (writes(wb, r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [7:0] ref_out(input ins_t id);
        ins_t       ex;
        ins_t       mem;
        ins_t       wb;
        logic       st;
        logic [4:0] src [2];
        logic       used[2];
        logic       ba;
        logic       bb;
        ex  = hist[0];
        mem = hist[1];
        wb  = hist[2];
        src[0]  = id.rs;  src[1]  = id.rt;
        used[0] = id.urs; used[1] = id.urt;
        st = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (id.valid && used[k]) begin
                // Producer one instruction ahead: loads always wait, and
                // branches wait for any producer.
                if (writes(ex, src[k]) && (ex.mr || id.br)) st = 1'b1;
                // Producer two ahead: only a branch waiting on a load.
                if (id.br && writes(mem, src[k]) && mem.mr) st = 1'b1;
            end
        end
        ba = id.valid && id.br && id.urs && writes(mem, id.rs) && !mem.mr;
        bb = id.valid && id.br && id.urt && writes(mem, id.rt) && !mem.mr;
        return {st, st,
                operand_src(mem, wb, ex.urs, ex.rs),
                operand_src(mem, wb, ex.urt, ex.rt),
                ba, bb};
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back('0);
        last_id    = '0;
        last_stall = 1'b0;
    endtask

    // Called at a rising edge: the held ID instruction moves to EX unless
    // it was stalled or was a bubble.
    task automatic model_advance();
        ins_t nx;
        if (!rst_n) begin
            model_clear();
        end else begin
            nx = (last_stall || !last_id.valid) ? ins_t'('0) : last_id;
            hist.push_front(nx);
            void'(hist.pop_back());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input ins_t ins);
        i_id_valid    = ins.valid;
        i_id_rs       = ins.rs;
        i_id_rt       = ins.rt;
        i_id_uses_rs  = ins.urs;
        i_id_uses_rt  = ins.urt;
        i_id_dest     = ins.dest;
        i_id_regwrite = ins.rw;
        i_id_memread  = ins.mr;
        i_id_branch   = ins.br;
    endtask

    // One pipeline cycle with `ins` in ID. Returns at negedge+1 so that
    // directed checks can look at the same cycle's outputs.
    task automatic issue(input ins_t ins, output logic st);
        logic [7:0] e;
        @(posedge clk);
        model_advance();
        #1;
        drive(ins);
        e = ref_out(ins);
        exp_q.push_back(e);
        last_id    = ins;
        last_stall = e[7];
        st         = e[7];
        @(negedge clk);
        #1;
    endtask

    task automatic issue1(input ins_t ins);
        logic st;
        issue(ins, st);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic ins_t alu(input int d, input int s, input int t);
        ins_t i;
        i = '0;
        i.valid = 1'b1; i.rs = 5'(s); i.rt = 5'(t); i.urs = 1'b1; i.urt = 1'b1;
        i.dest = 5'(d); i.rw = 1'b1;
        return i;
    endfunction

    function automatic ins_t lw(input int d, input int base);
        ins_t i;
        i = '0;
        i.valid = 1'b1; i.rs = 5'(base); i.rt = 5'(d); i.urs = 1'b1;
        i.dest = 5'(d); i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic ins_t beq(input int s, input int t);
        ins_t i;
        i = '0;
        i.valid = 1'b1; i.rs = 5'(s); i.rt = 5'(t); i.urs = 1'b1; i.urt = 1'b1;
        i.br = 1'b1;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        int   kind;
        kind = $urandom_range(0, 9);
        i = alu($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        if (kind <= 3) begin
            i.urt = ($urandom_range(0, 3) != 0);
        end else if (kind <= 5) begin
            i = lw($urandom_range(0, 7), $urandom_range(0, 7));
        end else if (kind <= 7) begin
            i = beq($urandom_range(0, 7), $urandom_range(0, 7));
        end else if (kind == 8) begin
            i.rw = 1'b0;
        end else begin
            i.valid = 1'b0;
            i.mr    = 1'($urandom_range(0, 1));
            i.br    = 1'($urandom_range(0, 1));
        end
        return i;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (dut_out() !== e) begin
                n_fail++;
                $display("FAIL scoreboard cycle %0d: got %b, expected %b", cyc, dut_out(), e);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    ins_t nop;
    ins_t x;

    // ---------------- stimulus ----------------
    initial begin
        logic st;
        int   tries;
        nop = '0;
        model_clear();

        // Reset with arbitrary ID inputs: everything quiet.
        rst_n = 1'b0;
        drive(alu(3, 3, 3) | ins_t'({1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b1}));
        #3;
        check("reset_outputs", dut_out(), 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(nop);
        #1;
        check("after_release_idle", dut_out(), 8'h00);
        issue1(nop);
        issue1(nop);
        check("idle_outputs", dut_out(), 8'h00);

        // ALU -> ALU back to back: MEM forward on A.
        issue1(alu(3, 1, 2));
        issue1(alu(4, 3, 5));
        issue1(nop);
        check("alu_chain_mem_fwd_a", {6'd0, o_fwd_a_sel}, 8'd2);
        check("alu_chain_b_reg",     {6'd0, o_fwd_b_sel}, 8'd0);

        // One independent instruction in between: WB forward.
        issue1(alu(3, 1, 2));
        issue1(alu(10, 11, 12));
        issue1(alu(4, 3, 5));
        issue1(nop);
        check("alu_gap_wb_fwd_a", {6'd0, o_fwd_a_sel}, 8'd1);

        // Writes to $0 never forward.
        issue1(alu(0, 1, 2));
        issue1(alu(4, 0, 5));
        issue1(nop);
        check("reg0_no_fwd", {6'd0, o_fwd_a_sel}, 8'd0);

        // $3 written by both MEM and WB: MEM wins. Operand on B this time.
        issue1(alu(3, 1, 2));
        issue1(alu(3, 6, 7));
        issue1(alu(4, 5, 3));
        issue1(nop);
        check("double_match_mem_fwd_b", {6'd0, o_fwd_b_sel}, 8'd2);
        repeat (3) issue1(nop);

        // Load-use: exactly one stall, then WB forward.
        issue1(lw(2, 1));
        issue1(alu(6, 2, 7));
        check("load_use_stall", {6'd0, o_stall, o_idex_flush}, 8'd3);
        issue1(alu(6, 2, 7));
        check("load_use_one_cycle", {7'd0, o_stall}, 8'd0);
        issue1(nop);
        check("load_use_wb_fwd_a", {6'd0, o_fwd_a_sel}, 8'd1);
        repeat (3) issue1(nop);

        // Branch after ALU producer: one stall, then bypass.
        issue1(alu(8, 1, 2));
        issue1(beq(8, 9));
        check("br_alu_stall", {7'd0, o_stall}, 8'd1);
        issue1(beq(8, 9));
        check("br_alu_bypass", {6'd0, o_stall, o_br_fwd_a}, 8'd1);
        repeat (3) issue1(nop);

        // Branch after load: two stalls, no bypass afterwards.
        issue1(lw(8, 1));
        issue1(beq(9, 8));
        check("br_load_stall1", {7'd0, o_stall}, 8'd1);
        issue1(beq(9, 8));
        check("br_load_stall2", {6'd0, o_stall, o_br_fwd_b}, 8'd2);
        issue1(beq(9, 8));
        check("br_load_release", {6'd0, o_stall, o_br_fwd_b}, 8'd0);
        repeat (3) issue1(nop);

        // Invalid ID with matching fields: no stall, bubble into EX.
        issue1(lw(2, 1));
        x = alu(6, 2, 2);
        x.valid = 1'b0;
        issue1(x);
        check("invalid_id_no_stall", {7'd0, o_stall}, 8'd0);
        issue1(nop);
        check("invalid_id_bubble", dut_out(), 8'h00);
        repeat (3) issue1(nop);

        // Reset during a load-use stall.
        issue1(lw(2, 1));
        issue1(alu(6, 2, 7));
        check("pre_reset_stall", {7'd0, o_stall}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_stall", {6'd0, o_stall, o_idex_flush}, 8'd0);
        issue1(nop);
        issue1(nop);
        rst_n = 1'b1;
        issue1(alu(6, 2, 7));
        check("post_reset_no_stall", {7'd0, o_stall}, 8'd0);
        issue1(nop);
        check("post_reset_empty", dut_out(), 8'h00);

        // Random instruction stream on a small register set.
        for (int n = 0; n < 400; n++) begin
            x = rand_ins();
            tries = 0;
            do begin
                issue(x, st);
                tries++;
            end while (st && tries < 4);
        end
        repeat (3) issue1(nop);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
